uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter that drives the SoC `TXD` pin, which is currently tied low. It sits downstream of the pattern/LED sequencer, or later the CPU's memory-mapped I/O. It accepts one byte per valid/ready handshake and shifts it out as an 8N1 frame, optionally with an even-parity bit. The sequencer can then report each LED pattern over the serial link.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 12000000: frequency of `clk`.
- `BAUD_RATE`, default 115200: line rate.
- `CLKS_PER_BIT`, default `CLK_FREQ_HZ/BAUD_RATE` (integer division, 104 at defaults): cycles per bit. Values below 2 are unsupported.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `data`, in, 8: byte to send; sampled only on acceptance.
- `valid`, in, 1: producer has a byte on `data`.
- `ready`, out, 1: transmitter can accept; high exactly when FSM is IDLE.
- `busy`, out, 1: frame in progress; equals `!ready`.
- `tx`, out, 1: serial line, idle high. Registered output; no combinational path from any input.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only when parity is compiled in), STOP.
- Acceptance occurs on a rising edge where `valid && ready`.
  - The block latches `data` into an 8-bit shift register.
  - The bit-cycle counter clears, the bit index clears, and the FSM moves to START.
- IDLE: `tx`=1. `valid` while not ready is ignored; the producer must hold it.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: sends 8 bits, LSB first, each for `CLKS_PER_BIT` cycles. After bit 7, goes to PARITY if compiled in, else STOP.
- PARITY: `tx` = XOR of the latched byte (even parity) for `CLKS_PER_BIT` cycles, then STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- Bit-cycle counter:
  - width is `$clog2(CLKS_PER_BIT)`;
  - counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary;
  - never overflows.
- Bit index is 3 bits; the DATA exit condition is index==7 at counter terminal count.
- Changes on `data` or `valid` during a frame have no effect on the frame in flight.

## Timing
- Reset values (applied immediately on `resetn` low, independent of `clk`): FSM=IDLE, `tx`=1, `ready`=1, `busy`=0, counter=0, shift register=0.
- Reset mid-frame: the frame is abandoned, `tx` returns high asynchronously, and no partial data is resumed after release.
- Latency: the start bit (`tx` low) appears on the first edge after acceptance, i.e. the cycle following the handshake.
- `ready` falls in that same cycle and stays low for the whole frame.
- Frame occupancy is 10×`CLKS_PER_BIT` cycles (11× with parity) from the start-bit edge to IDLE re-entry.
- Back-to-back transfers:
  - `ready` is high for at least one IDLE cycle after STOP;
  - with `valid` held high, the next start bit begins exactly 10×`CLKS_PER_BIT`+1 cycles after the previous start bit (11×+1 with parity).
- Simultaneous `valid` and STOP terminal count: not accepted that cycle (`ready` is still 0); accepted on the following IDLE cycle.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: the PARITY state exists and one even-parity bit is inserted between bit 7 and stop; frame is 11 bits.
- Undefined: PARITY state and XOR logic are not generated; frame is 8N1, 10 bits.

## Test plan
Run with `CLK_FREQ_HZ`=400 and `BAUD_RATE`=100, giving `CLKS_PER_BIT`=4.
- Reset: assert `resetn`=0 mid-simulation without a clock edge -> `tx`=1, `ready`=1, `busy`=0 immediately.
- Single byte 0x55, parity off:
  - `tx` after the handshake is 0, 1,0,1,0,1,0,1,0, 1, each bit held 4 cycles;
  - `ready` low for exactly 40 cycles, then high.
- Back-to-back 0xA5 then 0x3C with `valid` held high, parity off:
  - second start bit falls 41 cycles after the first;
  - data bits decode to 0xA5 then 0x3C, LSB first.
- Reset mid-frame: drop `resetn` during data bit 3 of 0xF0, then release:
  - `tx`=1 and `ready`=1 at once;
  - no further low bits until a new handshake.
- Parity on (`UART_TX_PARITY_EN` defined), send 0x07:
  - parity bit = 1;
  - frame occupies 44 cycles;
  - sending 0x03 gives parity bit = 0.
- Input change during frame: accept 0x81, then drive `data`=0xFF with `valid`=1 throughout -> decoded frame is 0x81; 0xFF is sent as the next frame.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : valid/ready byte-in, 8N1 serial-out transmitter.
//           Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_done;

  assign bit_done = (bit_cnt == CNT_LAST);

  // tx is loaded with the value of the *next* bit on each boundary so the line
  // is purely registered and changes exactly on the bit edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      tx      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            shreg   <= data;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            tx      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= ^shreg;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Return to IDLE with ready high; a pending valid is taken next cycle.
          if (bit_done) begin
            bit_cnt <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx      <= 1'b1;
          ready   <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : scoreboard bench for uart_tx at CLKS_PER_BIT = 4.
// Revision   : 1.0
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       valid  = 1'b0;
  logic [7:0] data   = 8'h00;
  logic       ready;
  logic       busy;
  logic       tx;

  int         compared   = 0;
  int         mismatched = 0;
  longint     accept_t   = 0;
  logic [8:0] exp_q[$];

  uart_tx #(
    .CLK_FREQ_HZ(400),
    .BAUD_RATE  (100)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: decode each frame from the line and compare with the queue head.
  initial begin : monitor
    logic [10:0] bits;
    bit          aborted;
    bit          unstable;
    logic [8:0]  e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) begin
        bits     = '0;
        aborted  = 1'b0;
        unstable = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (resetn !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) bits[k/CPB] = tx;
          else if (tx !== bits[k/CPB]) unstable = 1'b1;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", int'(bits[8:1]), int'(e[7:0]));
            check("frame_start_stop_stable", int'({bits[0], bits[NB-1], unstable}), 2);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", int'(bits[9]), int'(e[8]));
`endif
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input logic par, input bit keep_valid);
    int n;
    n     = 0;
    data  = b;
    valid = 1'b1;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      check("accept_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    accept_t = $time;
    exp_q.push_back({par, b});
    @(negedge clk);
    if (!keep_valid) valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic single(input logic [7:0] b, input logic par);
    int n;
    send(b, par, 1'b0);
    check("start_latency_tx", int'(tx), 0);
    check("busy_in_frame", int'(busy), 1);
    wait_ready(n);
    check("ready_low_cycles", n, FRAME_CYC);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    int     n;
    int     lows;
    longint t1;

    #3 resetn = 1'b0;
    #10;
    check("reset_tx", int'(tx), 1);
    check("reset_ready", int'(ready), 1);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    single(8'h55, 1'b0);
    single(8'h07, 1'b1);
    single(8'h03, 1'b0);

    // Back-to-back with valid held: STOP terminal count must not accept.
    send(8'hA5, 1'b0, 1'b1);
    t1 = accept_t;
    send(8'h3C, 1'b0, 1'b0);
    check("b2b_start_spacing", int'((accept_t - t1) / 10), FRAME_CYC + 1);
    wait_ready(n);
    repeat (3) @(negedge clk);

    // Inputs changing during a frame must not disturb it.
    send(8'h81, 1'b0, 1'b1);
    data = 8'hFF;
    repeat (10) @(negedge clk);
    send(8'hFF, 1'b0, 1'b0);
    wait_ready(n);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0xF0 (that bit is 0 on the line).
    data  = 8'hF0;
    valid = 1'b1;
    wait_ready(n);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (16) @(negedge clk);
    check("bit3_low_before_reset", int'(tx), 0);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_tx", int'(tx), 1);
    check("async_reset_ready", int'(ready), 1);
    check("async_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_resume_after_reset", lows, 0);

    single(8'h5A, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
